// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one WIDTH/STAGES-bit ripple slice per stage,
// valid/ready handshake with whole-pipeline stall, registered result and flags.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic              adv;
    logic [WIDTH-1:0]  a_in      [STAGES];
    logic [WIDTH-1:0]  b_in      [STAGES];
    logic [WIDTH-1:0]  a_nx      [STAGES];
    logic [SW:0]       slice_sum [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_nx;

    // a_q holds finished result slices below the stage boundary and raw A above it
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic              ovf_q;
    logic              zero_q;

    logic              msb_cin;
    logic              ovf_nx;
    logic              zero_nx;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    always_comb begin
        c_in = '0;
        v_in = '0;
        c_nx = '0;
        a_in[0] = operand_a;
        b_in[0] = sub ? ~operand_b : operand_b;
        c_in[0] = sub;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = cy_q[k-1];
            v_in[k] = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                         + {{SW{1'b0}}, c_in[k]};
            a_nx[k] = a_in[k];
            a_nx[k][k*SW +: SW] = slice_sum[k][SW-1:0];
            c_nx[k] = slice_sum[k][SW];
        end
    end

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits
    assign msb_cin = a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1] ^ a_nx[L][WIDTH-1];
    assign ovf_nx  = msb_cin ^ c_nx[L];
    assign zero_nx = (a_nx[L] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k]  <= a_nx[k];
                    b_q[k]  <= b_in[k];
                    cy_q[k] <= c_nx[k];
                end
            end
            if (v_in[L]) begin
                ovf_q  <= ovf_nx;
                zero_q <= zero_nx;
            end
        end
    end

    assign out_valid = vld_q[L];
    assign result    = a_q[L];
    assign carry_out = cy_q[L];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub, run concurrently on four (WIDTH, STAGES) configurations.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    wire [3:0] done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W = (g == 2) ? 32 : (g == 3) ? 8 : 16;
        localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 8;

        logic rst_n, in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow, zero;
        logic [W-1:0] operand_a, operand_b, result;
        logic [W+2:0] exp_q[$];
        bit stalled;
        bit done_b;
        assign done[g] = done_b;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .operand_a(operand_a), .operand_b(operand_b), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready), .result(result),
            .carry_out(carry_out), .overflow(overflow), .zero(zero)
        );

        // {zero, overflow, carry, result}
        function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
            logic [W:0] full;
            longint sa, sb, r, lim;
            sa = $signed(a);
            sb = $signed(b);
            if (s) begin
                full = {(a >= b), a - b};
                r = sa - sb;
            end else begin
                full = {1'b0, a} + {1'b0, b};
                r = sa + sb;
            end
            lim = longint'(1) <<< (W - 1);
            return {(full[W-1:0] == '0), ((r >= lim) || (r < -lim)), full};
        endfunction

        task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic ordy, input bit use_exp,
                            input logic [W+2:0] exp_v, output bit seen);
            @(negedge clk);
            seen = out_valid;
            if (stalled) check($sformatf("cfg%0d stall_hold_valid", g), out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0)
                    check($sformatf("cfg%0d spurious_valid", g), out_valid, 0);
                else
                    check($sformatf("cfg%0d result_flags", g),
                          {zero, overflow, carry_out, result}, exp_q[0]);
            end
            in_valid  = iv;
            operand_a = a;
            operand_b = b;
            sub       = s;
            out_ready = ordy;
            #1;
            check($sformatf("cfg%0d in_ready", g), in_ready, !(out_valid && !ordy));
            stalled = out_valid && !ordy;
            if (out_valid && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (iv && in_ready) exp_q.push_back(use_exp ? exp_v : model(a, b, s));
        endtask

        initial begin
            bit seen;
            int lat;
            int acc;
            logic [W-1:0] ones, minv, maxv;
            ones = '1;
            minv = {1'b1, {(W-1){1'b0}}};
            maxv = ~minv;
            rst_n = 1'b0; in_valid = 1'b0; operand_a = '0; operand_b = '0;
            sub = 1'b0; out_ready = 1'b0; stalled = 1'b0; done_b = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("cfg%0d reset_valid", g), out_valid, 0);
            check($sformatf("cfg%0d reset_outputs", g), {zero, overflow, carry_out, result}, 0);
            check($sformatf("cfg%0d reset_in_ready", g), in_ready, 1);
            rst_n = 1'b1;

            // latency with an empty pipe and no back-pressure
            step(1'b1, W'(5), W'(3), 1'b0, 1'b1, 1'b0, '0, seen);
            lat = 0;
            for (int j = 1; j <= S + 4 && lat == 0; j++) begin
                step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, seen);
                if (seen) lat = j;
            end
            check($sformatf("cfg%0d latency", g), lat, S);

            // corner cases with constant expectations
            step(1'b1, ones, W'(1), 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, {W{1'b0}}}, seen);
            step(1'b1, minv, W'(1), 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, maxv}, seen);
            step(1'b1, W'(3), W'(5), 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, ones - W'(1)}, seen);
            step(1'b1, maxv, W'(1), 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, minv}, seen);
            for (int j = 0; j < 80 && exp_q.size() > 0; j++)
                step(1'b0, '0, '0, 1'b0, (j % 3) != 0, 1'b0, '0, seen);
            check($sformatf("cfg%0d directed_drain", g), exp_q.size(), 0);

            // asynchronous reset with operations in flight
            for (int j = 0; j < 3; j++)
                step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0, '0, seen);
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, seen);
            #2 rst_n = 1'b0;
            #1;
            check($sformatf("cfg%0d async_reset_valid", g), out_valid, 0);
            check($sformatf("cfg%0d async_reset_outputs", g), {zero, overflow, carry_out, result}, 0);
            exp_q.delete();
            stalled = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check($sformatf("cfg%0d post_reset_in_ready", g), in_ready, 1);
            for (int j = 0; j < 2 * S + 4; j++)
                step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, seen);

            // random traffic with random back-pressure
            acc = 0;
            for (int j = 0; j < 12000 && acc < 1500; j++) begin
                logic iv;
                iv = ($urandom_range(0, 99) < 70);
                step(iv, W'($urandom), W'($urandom), 1'($urandom),
                     ($urandom_range(0, 99) < 75), 1'b0, '0, seen);
                if (iv && in_ready) acc++;
            end
            check($sformatf("cfg%0d accepted", g), acc, 1500);
            for (int j = 0; j < 4 * S + 20 && exp_q.size() > 0; j++)
                step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, seen);
            check($sformatf("cfg%0d final_queue", g), exp_q.size(), 0);
            done_b = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 80000 && done != 4'hF; t++) @(posedge clk);
        check("all_done", done, 4'hF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
